// File: rtl/lpf_coeff_loader_if.sv
// ---------------------------------------------------------------------------
// lpf_coeff_loader_if
// Coefficient stream from a host/control source into lpf_coeff_loader.
// Signal suffixes are named from the loader's point of view, so the names
// match the loader's documented ports.
//   coef_valid_i  : a coefficient word is present
//   coef_data_i   : coefficient word (tap 0 first), COEFFICIENT_LEN bits
//   coef_last_i   : final word of a set, qualified by coef_valid_i
//   coef_ready_o  : loader can accept a word
// Modports: master = stream source, slave = lpf_coeff_loader.
// ---------------------------------------------------------------------------
interface lpf_coeff_loader_if #(
  parameter int COEFFICIENT_LEN = 16
);
  logic                       coef_valid_i;
  logic [COEFFICIENT_LEN-1:0] coef_data_i;
  logic                       coef_last_i;
  logic                       coef_ready_o;

  modport master (
    output coef_valid_i,
    output coef_data_i,
    output coef_last_i,
    input  coef_ready_o
  );

  modport slave (
    input  coef_valid_i,
    input  coef_data_i,
    input  coef_last_i,
    output coef_ready_o
  );
endinterface

// File: rtl/lpf_coeff_loader.sv
// ---------------------------------------------------------------------------
// lpf_coeff_loader
// Collects TAP_NUM coefficient words from a valid/ready stream into a shadow
// bank and copies the whole bank to coeff_o in one edge once the filter
// reports a safe point (commit_ok_i). Malformed sets are discarded.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   coef_if (slave) : coefficient stream (valid/data/last in, ready out)
//   commit_ok_i     : filter is at a safe point to swap coefficients
//   coeff_o         : active bank, coeff_o[k] is tap k (bit-exact words)
//   coeff_update_o  : one-cycle pulse in the cycle after a commit
//   load_err_o      : one-cycle pulse when a malformed set is discarded
//   busy_o          : high while the state is not IDLE
// ---------------------------------------------------------------------------
module lpf_coeff_loader #(
  parameter int TAP_NUM         = 16,
  parameter int COEFFICIENT_LEN = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  lpf_coeff_loader_if.slave                       coef_if,
  input  logic                                    commit_ok_i,
  output logic [TAP_NUM-1:0][COEFFICIENT_LEN-1:0] coeff_o,
  output logic                                    coeff_update_o,
  output logic                                    load_err_o,
  output logic                                    busy_o
);

  localparam int IDX_W = (TAP_NUM > 1) ? $clog2(TAP_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAP_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  // Set after a long-set error: swallow words through the next coef_last_i.
  logic                                    drain_q, drain_d;
  logic                                    ready_q, ready_d;
  logic                                    busy_q, busy_d;
  logic                                    upd_q, upd_d;
  logic                                    err_q, err_d;
  logic [TAP_NUM-1:0][COEFFICIENT_LEN-1:0] coeff_q, coeff_d;
  logic [TAP_NUM-1:0][COEFFICIENT_LEN-1:0] shadow_q;
  logic                                    accept_s;
  logic                                    wr_en_s;

  assign accept_s = coef_if.coef_valid_i & ready_q;

  // Next-state logic for the IDLE/LOAD/PEND loader FSM and its outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    coeff_d = coeff_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (accept_s) begin
          if (drain_q) begin
            // Dropped word of a discarded long set; stay in IDLE.
            if (coef_if.coef_last_i) begin
              drain_d = 1'b0;
            end else begin
              drain_d = 1'b1;
            end
          end else begin
            wr_en_s = 1'b1;
            if (idx_q == LAST_IDX) begin
              if (coef_if.coef_last_i) begin
                state_d = PEND;
              end else begin
                // Long set: more words than taps.
                err_d   = 1'b1;
                state_d = IDLE;
                idx_d   = '0;
                drain_d = 1'b1;
              end
            end else if (coef_if.coef_last_i) begin
              // Short set: last marker before the final tap.
              err_d   = 1'b1;
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              state_d = LOAD;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      PEND: begin
        if (commit_ok_i) begin
          coeff_d = shadow_q;
          upd_d   = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        drain_d = 1'b0;
      end
    endcase
    // ready/busy are registered copies derived from the next state.
    ready_d = (state_d != PEND);
    busy_d  = (state_d != IDLE);
  end

  // FSM and output registers; reset clears the active bank asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      coeff_q <= coeff_d;
    end
  end

  // Shadow bank write; contents are don't-care until a full set is held.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      shadow_q[idx_q] <= coef_if.coef_data_i;
    end
  end

  assign coef_if.coef_ready_o = ready_q;
  assign coeff_o              = coeff_q;
  assign coeff_update_o       = upd_q;
  assign load_err_o           = err_q;
  assign busy_o               = busy_q;

endmodule

// File: tb/tb_lpf_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_lpf_coeff_loader
// Directed, self-checking bench for lpf_coeff_loader (TAP_NUM=16, 16-bit
// words). A vector table covers a back-to-back full load with commit_ok held
// high; hand-written sequences cover deferred commit, short/long sets and
// reset during LOAD.
// ---------------------------------------------------------------------------
module tb_lpf_coeff_loader;

  localparam int TN = 16;
  localparam int CL = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   commit_ok;
  logic [TN-1:0][CL-1:0]  coeff;
  logic                   upd;
  logic                   err;
  logic                   busy;
  logic [TN-1:0][CL-1:0]  model;

  int n_cmp = 0;
  int n_bad = 0;

  lpf_coeff_loader_if #(.COEFFICIENT_LEN(CL)) cif ();

  lpf_coeff_loader #(.TAP_NUM(TN), .COEFFICIENT_LEN(CL)) dut (
    .clk            (clk),
    .rst            (rst),
    .coef_if        (cif),
    .commit_ok_i    (commit_ok),
    .coeff_o        (coeff),
    .coeff_update_o (upd),
    .load_err_o     (err),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        c;
    logic        e_rdy;
    logic        e_busy;
    logic        e_upd;
    logic        e_err;
    logic [15:0] e_t0;
    logic [15:0] e_t15;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bank(input string nm, input logic [TN-1:0][CL-1:0] exp);
    n_cmp++;
    if (coeff !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, coeff, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic rdy, input logic bsy,
                          input logic up, input logic er);
    chk({nm, ".ready"},  {31'd0, cif.coef_ready_o}, {31'd0, rdy});
    chk({nm, ".busy"},   {31'd0, busy}, {31'd0, bsy});
    chk({nm, ".update"}, {31'd0, upd},  {31'd0, up});
    chk({nm, ".err"},    {31'd0, err},  {31'd0, er});
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic c);
    cif.coef_valid_i = v;
    cif.coef_data_i  = d;
    cif.coef_last_i  = l;
    commit_ok        = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full-load table: words 1..16, commit_ok high all the way.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, 16'(i + 1), (i == 15), 1'b1,
                 (i != 15), 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    end
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0010};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0010};

    rst              = 1'b1;
    cif.coef_valid_i = 1'b0;
    cif.coef_data_i  = 16'h0000;
    cif.coef_last_i  = 1'b0;
    commit_ok        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_bank("reset.coeff", '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven full load with minimum-latency commit.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c);
      chk_outs($sformatf("full[%0d]", i), tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_upd, tbl[i].e_err);
      chk($sformatf("full[%0d].tap0", i),  {16'd0, coeff[0]},  {16'd0, tbl[i].e_t0});
      chk($sformatf("full[%0d].tap15", i), {16'd0, coeff[15]}, {16'd0, tbl[i].e_t15});
    end
    for (int k = 0; k < TN; k++) model[k] = 16'(k + 1);
    chk_bank("full.bank", model);

    // Deferred commit with extreme values.
    for (int k = 0; k < TN; k++) begin
      step(1'b1, (k == 0) ? 16'h8000 : ((k == 15) ? 16'h7FFF : 16'h0000), (k == 15), 1'b0);
    end
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      chk_outs($sformatf("defer[%0d]", n), 1'b0, 1'b1, 1'b0, 1'b0);
      chk_bank($sformatf("defer[%0d].bank", n), model);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_outs("defer.commit", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TN; k++) model[k] = 16'h0000;
    model[0]  = 16'h8000;
    model[15] = 16'h7FFF;
    chk_bank("defer.bank", model);

    // Short set: last marker on the 5th word.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 16'(16'h0050 + k), (k == 4), 1'b0);
    end
    chk_outs("short.err", 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_outs("short.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_bank("short.bank", model);
    for (int k = 0; k < TN; k++) step(1'b1, 16'(16'h0100 + k), (k == 15), 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_outs("short.reload", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TN; k++) model[k] = 16'(16'h0100 + k);
    chk_bank("short.reload.bank", model);

    // Long set: 17 words, last marker on the 17th.
    for (int k = 0; k < 15; k++) step(1'b1, 16'(16'h0A00 + k), 1'b0, 1'b1);
    chk_outs("long.w15", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0A0F, 1'b0, 1'b1);
    chk_outs("long.w16", 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0A10, 1'b1, 1'b1);
    chk_outs("long.w17", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_outs("long.idle", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_bank("long.bank", model);
    for (int k = 0; k < TN; k++) step(1'b1, 16'(16'hF000 + k), (k == 15), 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_outs("long.reload", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TN; k++) model[k] = 16'(16'hF000 + k);
    chk_bank("long.reload.bank", model);

    // Reset mid-cycle during LOAD after 8 words.
    for (int k = 0; k < 8; k++) step(1'b1, 16'(16'h0300 + k), 1'b0, 1'b1);
    chk_outs("rstload.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    cif.coef_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_outs("rstload.async", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_bank("rstload.bank", '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < TN; k++) step(1'b1, 16'(16'h0200 + k), (k == 15), 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_outs("rstload.reload", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TN; k++) model[k] = 16'(16'h0200 + k);
    chk_bank("rstload.reload.bank", model);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lpf_coeff_loader.md
# lpf_coeff_loader

Streaming coefficient writer for the `lpf` FIR block. Accepts coefficients one word per handshake from a control/host stream, assembles a full `TAP_NUM`-word set in a shadow bank, and commits it atomically to the parallel `coeff_o` bus that drives `lpf.coeff_i`. The commit happens only when the filter signals a safe point, so the filter never sees a partially updated set.

## Interface
- `TAP_NUM`, 16, number of filter taps / coefficients per set
- `COEFFICIENT_LEN`, 16, width of one signed coefficient

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `coef_valid_i`  in  1  a coefficient word is present
- `coef_data_i`  in  COEFFICIENT_LEN  signed coefficient word; tap 0 is sent first
- `coef_last_i`  in  1  marks the final word of a set; qualified by `coef_valid_i`
- `coef_ready_o`  out  1  the loader can accept a word
- `commit_ok_i`  in  1  the filter is at a safe point to swap coefficients
- `coeff_o`  out  TAP_NUM x COEFFICIENT_LEN  active coefficient bank; `coeff_o[k]` is tap k
- `coeff_update_o`  out  1  one-cycle pulse in the cycle after a commit
- `load_err_o`  out  1  one-cycle pulse when a malformed set is discarded
- `busy_o`  out  1  high while the state is not IDLE

## Operation
- **State machine:** IDLE, LOAD, PEND. The state is registered.
- **Handshake:** a word is accepted on any rising edge where `coef_valid_i && coef_ready_o`.
  - `coef_ready_o` is high in IDLE and LOAD and low in PEND.
  - `coef_ready_o` depends only on the registered state; there is no combinational path from `coef_valid_i`.
- **Write index:** `idx` is a counter of width `$clog2(TAP_NUM)`.
  - Each accepted word writes `shadow[idx]`, then `idx` increments.
  - `idx` returns to 0 whenever the state returns to IDLE.
- **IDLE:**
  - An accepted word moves the state to LOAD.
  - If that word is also the only word needed (`TAP_NUM=1` with `coef_last_i=1`), the state goes straight to PEND.
- **LOAD:**
  - Accepted word with `idx==TAP_NUM-1` and `coef_last_i=1`: go to PEND.
  - Accepted word with `coef_last_i=1` and `idx<TAP_NUM-1` (short set): pulse `load_err_o`, discard the set, go to IDLE.
  - Accepted word with `idx==TAP_NUM-1` and `coef_last_i=0` (long set): pulse `load_err_o`, discard the set, go to IDLE. All following words up to and including the next `coef_last_i` are dropped; the loader stays in IDLE but keeps `coef_ready_o=1` so the source drains.
- **PEND:**
  - Holds the complete shadow bank.
  - On the first edge with `commit_ok_i=1`: `coeff_o <= shadow` (all taps in the same edge), state goes to IDLE, and `coeff_update_o` is high for exactly the following cycle.
- **Discarded sets:** `coeff_o` never changes. The shadow contents are don't-care.
- **Arithmetic:** none. Coefficients pass through bit-exact, with no sign extension or reordering.

## Timing
- **Reset values:** state IDLE, `idx=0`, `coeff_o=0` (all taps), `coeff_update_o=0`, `load_err_o=0`, `busy_o=0`, `coef_ready_o=1` after reset deasserts. The shadow bank need not be reset.
- **Reset mid-load or in PEND:** the pending set is lost and `coeff_o` is cleared to 0 asynchronously.
- **Minimum latency,** from the last word accepted to `coeff_o` updated, with `commit_ok_i` held high:
  - Edge N accepts the last word; state becomes PEND.
  - Edge N+1 loads `coeff_o`.
  - `coeff_update_o` is high during cycle N+1 to N+2.
- **`commit_ok_i` high in IDLE or LOAD:** no effect.
- **`commit_ok_i` high on the same edge as the last word:** no commit yet; the commit happens on the next edge, because the state was LOAD on that edge.
- **Throughput:** one word per cycle when `coef_valid_i` is held high. The loader stalls the source in PEND until commit; the next set can start in the cycle after the commit.
- **Pulse outputs:** `load_err_o` and `coeff_update_o` are registered, one cycle wide, and never high in the same cycle.

## Test plan
- **Reset:** assert `rst` mid-cycle -> immediately `coeff_o==0`, `busy_o==0`, `coef_ready_o==1`.
- **Full load:** `TAP_NUM=16`, send words 16'sd1..16'sd16 back-to-back with `coef_last_i` on the 16th, `commit_ok_i=1` -> `coeff_o[0]==1`, `coeff_o[15]==16` one edge after the last word; one `coeff_update_o` pulse; no `load_err_o`.
- **Deferred commit:** load the set {-16'sd32768, 0, …, 16'sd32767} with `commit_ok_i=0` for 10 cycles -> `coef_ready_o=0`, `busy_o=1`, `coeff_o` unchanged for those cycles; raise `commit_ok_i` -> swap on the next edge; extreme values bit-exact.
- **Short set:** `coef_last_i` on the 5th word -> one `load_err_o` pulse, `coeff_o` unchanged, state IDLE; a following valid 16-word set commits normally.
- **Long set:** 17 words with `coef_last_i` on the 17th -> `load_err_o` on the 16th word, the 17th is dropped, `coeff_o` unchanged, no `coeff_update_o`.
- **Reset during LOAD:** `rst` after 8 words -> `coeff_o==0`; a following full set loads from tap 0.
